// File: rtl/nes_dump_pkg.sv
// Shared types and constants for the cartridge-dump path.
package nes_dump_pkg;

    localparam int unsigned CHR_ADDR_W = 14;
    localparam int unsigned CHR_SIZE   = 8192;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SEND,
        WAIT_ACK,
        WAIT_DONE,
        CKSUM,
        FINISH
    } dump_state_t;

endpackage

// File: rtl/edge_detect_rise.sv
// Registered rising-edge detector for a level input such as a slide switch.
module edge_detect_rise (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            sig_q <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sig_q <= sig;
            rise  <= sig & ~sig_q;
        end
    end

endmodule

// File: rtl/chr_dump_sequencer.sv
// Walks the CHR address range and hands each byte to the UART over valid/done.
// Define CHR_DUMP_CHECKSUM_EN to append an 8-bit running-sum byte after the data.
module chr_dump_sequencer
    import nes_dump_pkg::*;
#(
    parameter int unsigned       ADDR_W        = CHR_ADDR_W,
    parameter logic [ADDR_W-1:0] START_ADDR    = '0,
    parameter logic [ADDR_W-1:0] END_ADDR      = ADDR_W'(CHR_SIZE - 1),
    parameter int unsigned       SETTLE_CYCLES = 4
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              start,
    input  logic [7:0]        ppu_d,
    output logic [ADDR_W-1:0] ppu_a,
    output logic              ppu_rd_n,
    input  logic              uart_done,
    output logic              uart_valid,
    output logic [7:0]        uart_data,
    output logic              busy,
    output logic              finished
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_n_q, rd_n_d;
    logic              valid_q, valid_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              start_rise;
`ifdef CHR_DUMP_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic              ck_sent_q, ck_sent_d;
`endif

    edge_detect_rise u_start_edge (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .sig      (start),
        .rise     (start_rise)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rd_n_d  = rd_n_q;
        valid_d = 1'b0;
        data_d  = data_q;
        cnt_d   = cnt_q;
`ifdef CHR_DUMP_CHECKSUM_EN
        sum_d     = sum_q;
        ck_sent_d = ck_sent_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d = READ;
                    addr_d  = START_ADDR;
                    rd_n_d  = 1'b0;
                    cnt_d   = '0;
`ifdef CHR_DUMP_CHECKSUM_EN
                    sum_d     = '0;
                    ck_sent_d = 1'b0;
`endif
                end
            end
            READ: begin
                if (cnt_q == SETTLE_LAST) begin
                    data_d  = ppu_d;
                    rd_n_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = SEND;
`ifdef CHR_DUMP_CHECKSUM_EN
                    sum_d = sum_q + ppu_d;
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SEND: begin
                if (uart_done) begin
                    valid_d = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!uart_done) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (uart_done) begin
`ifdef CHR_DUMP_CHECKSUM_EN
                    if (ck_sent_q) begin
                        state_d = FINISH;
                    end else if (addr_q != END_ADDR) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        rd_n_d  = 1'b0;
                        state_d = READ;
                    end else begin
                        state_d = CKSUM;
                    end
`else
                    // Terminate on compare so a full-range END_ADDR never wraps.
                    if (addr_q != END_ADDR) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        rd_n_d  = 1'b0;
                        state_d = READ;
                    end else begin
                        state_d = FINISH;
                    end
`endif
                end
            end
            CKSUM: begin
`ifdef CHR_DUMP_CHECKSUM_EN
                data_d    = sum_q;
                ck_sent_d = 1'b1;
                state_d   = SEND;
`else
                state_d = IDLE;
`endif
            end
            FINISH: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            addr_q  <= START_ADDR;
            rd_n_q  <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
`ifdef CHR_DUMP_CHECKSUM_EN
            sum_q     <= '0;
            ck_sent_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rd_n_q  <= rd_n_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
`ifdef CHR_DUMP_CHECKSUM_EN
            sum_q     <= sum_d;
            ck_sent_q <= ck_sent_d;
`endif
        end
    end

    assign ppu_a      = addr_q;
    assign ppu_rd_n   = rd_n_q;
    assign uart_valid = valid_q;
    assign uart_data  = data_q;
    assign busy       = (state_q != IDLE) && (state_q != FINISH);
    assign finished   = (state_q == FINISH);

endmodule

// File: tb/tb_chr_dump_sequencer.sv
// Directed bench: small 4-byte dump (with memory/UART models) plus a 4-bit full-range instance.
module tb_chr_dump_sequencer;

`ifdef CHR_DUMP_CHECKSUM_EN
    localparam int N_EXP   = 5;
    localparam int N_EXP_F = 17;
`else
    localparam int N_EXP   = 4;
    localparam int N_EXP_F = 16;
`endif

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N, start, bp;
    logic [7:0]  ppu_d, uart_data;
    logic [13:0] ppu_a;
    logic        ppu_rd_n, uart_done, uart_valid, busy, finished;
    logic        done_m = 1'b1;
    int          ucnt = 0;

    logic        start_f;
    logic [7:0]  ppu_d_f, uart_data_f;
    logic [3:0]  ppu_a_f;
    logic        ppu_rd_n_f, uart_done_f, uart_valid_f, busy_f, finished_f;
    logic        done_mf = 1'b1;
    int          ucnt_f = 0;

    int n_vec = 0;
    int n_err = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    chr_dump_sequencer #(
        .ADDR_W(14), .START_ADDR(14'h0000), .END_ADDR(14'h0003), .SETTLE_CYCLES(2)
    ) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .start(start), .ppu_d(ppu_d), .ppu_a(ppu_a),
        .ppu_rd_n(ppu_rd_n), .uart_done(uart_done), .uart_valid(uart_valid),
        .uart_data(uart_data), .busy(busy), .finished(finished)
    );

    chr_dump_sequencer #(
        .ADDR_W(4), .START_ADDR(4'h0), .END_ADDR(4'hF), .SETTLE_CYCLES(1)
    ) dut_full (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .start(start_f), .ppu_d(ppu_d_f),
        .ppu_a(ppu_a_f), .ppu_rd_n(ppu_rd_n_f), .uart_done(uart_done_f),
        .uart_valid(uart_valid_f), .uart_data(uart_data_f), .busy(busy_f),
        .finished(finished_f)
    );

    // Memory models: byte = addr ^ 5A
    assign ppu_d       = ppu_a[7:0] ^ 8'h5A;
    assign ppu_d_f     = {4'h0, ppu_a_f} ^ 8'h5A;
    assign uart_done   = done_m & ~bp;
    assign uart_done_f = done_mf;

    // UART models: done drops the cycle after valid, returns 10 cycles later
    always @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            done_m <= 1'b1; ucnt <= 0;
        end else if (uart_valid) begin
            done_m <= 1'b0; ucnt <= 10;
        end else if (ucnt != 0) begin
            ucnt <= ucnt - 1;
            if (ucnt == 1) done_m <= 1'b1;
        end
    end

    always @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            done_mf <= 1'b1; ucnt_f <= 0;
        end else if (uart_valid_f) begin
            done_mf <= 1'b0; ucnt_f <= 10;
        end else if (ucnt_f != 0) begin
            ucnt_f <= ucnt_f - 1;
            if (ucnt_f == 1) done_mf <= 1'b1;
        end
    end

    // Monitors
    logic [7:0]  pulses[$];
    logic [7:0]  pulses_f[$];
    int          runs[$];
    int          rd_len = 0;
    int          unstable = 0;
    logic        prev_rd_n = 1'b1;
    logic [13:0] prev_a = '0;
    logic [3:0]  prev_af = '0;
    logic        wrapped = 1'b0;

    always @(negedge CLOCK_50) begin
        if (uart_valid) pulses.push_back(uart_data);
        if (uart_valid_f) pulses_f.push_back(uart_data_f);
        if (!ppu_rd_n) begin
            if (!prev_rd_n && ppu_a !== prev_a) unstable <= unstable + 1;
            rd_len <= rd_len + 1;
        end else if (!prev_rd_n) begin
            runs.push_back(rd_len);
            rd_len <= 0;
        end
        prev_rd_n <= ppu_rd_n;
        prev_a    <= ppu_a;
        if (busy_f && ppu_a_f < prev_af) wrapped <= 1'b1;
        prev_af <= ppu_a_f;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ppu_a"}, 32'(ppu_a), 32'h0);
        check({tag, "_rd_n"}, 32'(ppu_rd_n), 32'h1);
        check({tag, "_valid"}, 32'(uart_valid), 32'h0);
        check({tag, "_data"}, 32'(uart_data), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_finished"}, 32'(finished), 32'h0);
    endtask

    task automatic wait_finished(input string name);
        int n = 0;
        while (!finished && n < 2000) begin
            @(negedge CLOCK_50);
            n++;
        end
        check(name, 32'(finished), 32'h1);
    endtask

    typedef struct {
        string      name;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[N_EXP];

    initial begin
        int          lat, base, n, first_runs;
        logic [7:0]  sum_f;

        vecs[0] = '{"byte_a0", 8'h5A};
        vecs[1] = '{"byte_a1", 8'h5B};
        vecs[2] = '{"byte_a2", 8'h58};
        vecs[3] = '{"byte_a3", 8'h59};
`ifdef CHR_DUMP_CHECKSUM_EN
        vecs[4] = '{"cksum", 8'h66};
`endif

        RESET_N = 1'b0; start = 1'b0; bp = 1'b0; start_f = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check_reset_outputs("reset");
        check("reset_full_a", 32'(ppu_a_f), 32'h0);
        @(negedge CLOCK_50) RESET_N = 1'b1;

        // Basic dump and first-byte latency
        @(negedge CLOCK_50) start = 1'b1;
        @(posedge CLOCK_50);
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge CLOCK_50);
            #1;
            lat++;
            if (uart_valid) break;
        end
        check("first_valid_latency", 32'(lat), 32'd4);
        wait_finished("basic_finish");
        check("basic_busy", 32'(busy), 32'h0);
        check("basic_rd_n", 32'(ppu_rd_n), 32'h1);
        check("basic_last_a", 32'(ppu_a), 32'h3);
        check("basic_count", 32'(pulses.size()), 32'(N_EXP));
        for (int i = 0; i < N_EXP; i++)
            if (i < pulses.size()) check(vecs[i].name, 32'(pulses[i]), 32'(vecs[i].data));
        first_runs = runs.size();
        check("rd_low_runs", 32'(first_runs), 32'd4);
        for (int i = 0; i < first_runs; i++) check("rd_low_len", 32'(runs[i]), 32'd2);
        check("a_stable", 32'(unstable), 32'd0);

        // Held start must not re-trigger; a low cycle then high restarts
        base = pulses.size();
        repeat (20) @(negedge CLOCK_50);
        check("hold_no_redump", 32'(pulses.size() - base), 32'd0);
        check("hold_finished", 32'(finished), 32'h1);
        start = 1'b0;
        @(negedge CLOCK_50) start = 1'b1;
        n = 0;
        while (!busy && n < 10) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("restart_busy", 32'(busy), 32'h1);
        wait_finished("restart_finish");
        check("restart_count", 32'(pulses.size() - base), 32'(N_EXP));
        for (int i = 0; i < N_EXP; i++)
            if (base + i < pulses.size())
                check({"restart_", vecs[i].name}, 32'(pulses[base + i]), 32'(vecs[i].data));

        // Backpressure ahead of the first SEND
        @(negedge CLOCK_50) start = 1'b0;
        @(negedge CLOCK_50) bp = 1'b1;
        @(negedge CLOCK_50) start = 1'b1;
        base = pulses.size();
        repeat (50) @(negedge CLOCK_50);
        check("bp_no_valid", 32'(pulses.size() - base), 32'd0);
        check("bp_busy", 32'(busy), 32'h1);
        bp = 1'b0;
        n = 0;
        while (pulses.size() == base && n < 10) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("bp_release_pulse", 32'(pulses.size() - base), 32'd1);
        if (pulses.size() > base) check("bp_first_data", 32'(pulses[base]), 32'h5A);
        repeat (6) @(negedge CLOCK_50);
        check("bp_single_pulse", 32'(pulses.size() - base), 32'd1);
        wait_finished("bp_finish");
        check("bp_count", 32'(pulses.size() - base), 32'(N_EXP));

        // Reset during the byte at address 2
        @(negedge CLOCK_50) start = 1'b0;
        @(negedge CLOCK_50) start = 1'b1;
        base = pulses.size();
        n = 0;
        while (!(ppu_a == 14'd2 && !ppu_rd_n) && n < 200) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("reach_addr2", 32'(ppu_a), 32'd2);
        check("pre_reset_count", 32'(pulses.size() - base), 32'd2);
        base = pulses.size();
        RESET_N = 1'b0;
        start   = 1'b0;
        @(posedge CLOCK_50);
        #1;
        check_reset_outputs("midreset");
        @(negedge CLOCK_50) RESET_N = 1'b1;
        repeat (40) @(negedge CLOCK_50);
        check("midreset_no_valid", 32'(pulses.size() - base), 32'd0);
        check("midreset_idle_busy", 32'(busy), 32'h0);
        check("midreset_idle_a", 32'(ppu_a), 32'h0);

        // Full 4-bit range: END_ADDR is the all-ones address
        @(negedge CLOCK_50) start_f = 1'b1;
        n = 0;
        while (!finished_f && n < 2000) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("full_finish", 32'(finished_f), 32'h1);
        check("full_count", 32'(pulses_f.size()), 32'(N_EXP_F));
        check("full_last_a", 32'(ppu_a_f), 32'hF);
        check("full_no_wrap", 32'(wrapped), 32'h0);
        check("full_busy", 32'(busy_f), 32'h0);
        if (pulses_f.size() >= 16) begin
            check("full_first", 32'(pulses_f[0]), 32'h5A);
            check("full_last", 32'(pulses_f[15]), 32'h55);
        end
`ifdef CHR_DUMP_CHECKSUM_EN
        sum_f = 8'h00;
        for (int i = 0; i < 16; i++) sum_f = sum_f + (8'(i) ^ 8'h5A);
        if (pulses_f.size() >= 17) check("full_cksum", 32'(pulses_f[16]), 32'(sum_f));
`else
        sum_f = 8'h00;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
